// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encoding, default memory-wait timeout and the register address width.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  localparam int PIPE_CTRL_TIMEOUT = 255;

endpackage

// File: rtl/load_use_check.sv
// Detects a D-stage instruction reading the destination of a load sitting in E,
// which the bypass network cannot cover. Register 0 never creates a hazard.
module load_use_check
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = `REG_SIZE
) (
  input  logic [REG_W-1:0] raddr1_i,
  input  logic [REG_W-1:0] raddr2_i,
  input  logic [REG_W-1:0] writeReg_i,
  input  logic             memToReg_i,
  output logic             loadUse_o
);

  logic srcMatch;

  assign srcMatch  = (raddr1_i == writeReg_i) || (raddr2_i == writeReg_i);
  assign loadUse_o = memToReg_i && (writeReg_i != '0) && srcMatch;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and stall scheduler for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and data-memory waits with a timeout watchdog. STALL_PERF_EN adds perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W   = `REG_SIZE,
  parameter int TIMEOUT = PIPE_CTRL_TIMEOUT,
  parameter int TMO_W   = 8
`ifdef STALL_PERF_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] raddr1D,
  input  logic [REG_W-1:0] raddr2D,
  input  logic [REG_W-1:0] writeRegE,
  input  logic             memToRegE,
  input  logic             branchTakenE,
  input  logic             dmemReqM,
  input  logic             dmemReadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             memErr,
`ifdef STALL_PERF_EN
  output logic [CNT_W-1:0] loadUseCnt,
  output logic [CNT_W-1:0] memStallCnt,
  output logic [CNT_W-1:0] flushCnt,
`endif
  output logic [1:0]       state
);

  ctrl_state_t      state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             memErr_q, memErr_d;
  logic             memStall;
  logic             loadUse;
  logic             active;

  assign memStall = dmemReqM && !dmemReadyM;
  assign active   = (state_q == RUN) || (state_q == MEM_WAIT);

  load_use_check #(.REG_W(REG_W)) u_load_use_check (
    .raddr1_i   (raddr1D),
    .raddr2_i   (raddr2D),
    .writeReg_i (writeRegE),
    .memToReg_i (memToRegE),
    .loadUse_o  (loadUse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      memErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memErr_q <= memErr_d;
    end
  end

  // cnt counts stall cycles of the current access, including the RUN-state cycle that started it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memErr_d = memErr_q;
    case (state_q)
      RUN: begin
        if (memStall) begin
          state_d = MEM_WAIT;
          cnt_d   = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmemReadyM || !dmemReqM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q >= TMO_W'(TIMEOUT)) begin
          state_d  = HALT;
          memErr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = HALT;
    endcase
  end

  // Priority: HALT > memStall > taken branch > load-use. HALT freezes like a memory stall.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (!reset) begin
      if (!active || memStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (branchTakenE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loadUse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  assign memErr = memErr_q;
  assign state  = state_q;

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] luCnt_q, msCnt_q, flCnt_q;
  logic             luEv, msEv, flEv;

  assign msEv = active && memStall;
  assign flEv = active && !memStall && branchTakenE;
  assign luEv = active && !memStall && !branchTakenE && loadUse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      luCnt_q <= '0;
      msCnt_q <= '0;
      flCnt_q <= '0;
    end else begin
      if (luEv && (luCnt_q != '1)) luCnt_q <= luCnt_q + CNT_W'(1);
      if (msEv && (msCnt_q != '1)) msCnt_q <= msCnt_q + CNT_W'(1);
      if (flEv && (flCnt_q != '1)) flCnt_q <= flCnt_q + CNT_W'(1);
    end
  end

  assign loadUseCnt  = luCnt_q;
  assign memStallCnt = msCnt_q;
  assign flushCnt    = flCnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=4); covers the
// STALL_PERF_EN counters when that macro is defined.
module tb_pipe_ctrl;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100010;
  localparam logic [6:0] BR   = 7'b0000110;
  localparam logic [6:0] MS   = 7'b1111001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raddr1D, raddr2D, writeRegE;
  logic       memToRegE, branchTakenE, dmemReqM, dmemReadyM;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
  logic [1:0] state;
`ifdef STALL_PERF_EN
  logic [31:0] loadUseCnt, memStallCnt, flushCnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_W(5), .TIMEOUT(4), .TMO_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .raddr1D      (raddr1D),
    .raddr2D      (raddr2D),
    .writeRegE    (writeRegE),
    .memToRegE    (memToRegE),
    .branchTakenE (branchTakenE),
    .dmemReqM     (dmemReqM),
    .dmemReadyM   (dmemReadyM),
    .stallF       (stallF),
    .stallD       (stallD),
    .stallE       (stallE),
    .stallM       (stallM),
    .flushD       (flushD),
    .flushE       (flushE),
    .flushW       (flushW),
    .memErr       (memErr),
`ifdef STALL_PERF_EN
    .loadUseCnt   (loadUseCnt),
    .memStallCnt  (memStallCnt),
    .flushCnt     (flushCnt),
`endif
    .state        (state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic [6:0] expCtrl, input logic [1:0] expState);
    checkOutput({tag, ".ctrl"}, {25'd0, stallF, stallD, stallE, stallM, flushD, flushE, flushW},
                {25'd0, expCtrl});
    checkOutput({tag, ".state"}, {30'd0, state}, {30'd0, expState});
  endtask

  // Inputs change just after the rising edge; the caller checks at the following falling edge.
  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                               input logic m2r, input logic br, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    raddr1D      = r1;
    raddr2D      = r2;
    writeRegE    = wr;
    memToRegE    = m2r;
    branchTakenE = br;
    dmemReqM     = req;
    dmemReadyM   = rdy;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset between clock edges, checks the asynchronous effect, then releases it.
  task automatic resetPulse(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkCtrl(tag, NONE, 2'd0);
    checkOutput({tag, ".memErr"}, {31'd0, memErr}, 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    branchTakenE = 1'b0;
    dmemReqM     = 1'b0;
    dmemReadyM   = 1'b0;
    memToRegE    = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    raddr1D      = '0;
    raddr2D      = '0;
    writeRegE    = '0;
    memToRegE    = 1'b0;
    branchTakenE = 1'b0;
    dmemReqM     = 1'b1;
    dmemReadyM   = 1'b0;
    repeat (2) @(negedge clk);
    checkCtrl("reset", NONE, 2'd0);
    checkOutput("reset.memErr", {31'd0, memErr}, 32'd0);
    dmemReqM = 1'b0;
    reset    = 1'b0;

    applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("luSrc1", LU, 2'd0);
    applyStimulus(5'd5, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("luCleared", NONE, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("luReg0", NONE, 2'd0);
    applyStimulus(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("luSrc2", LU, 2'd0);
    applyStimulus(5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("noLoad", NONE, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("branch", BR, 2'd0);
    applyStimulus(5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCtrl("branchOverLu", BR, 2'd0);

    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCtrl("memW1", MS, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCtrl("memW2", MS, 2'd1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCtrl("memW3", MS, 2'd1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkCtrl("memReady", NONE, 2'd1);
    idle();
    checkCtrl("memBackRun", NONE, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkCtrl("readySame", NONE, 2'd0);
    idle();
    checkCtrl("readySameAfter", NONE, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCtrl("squashA", MS, 2'd0);
    idle();
    checkCtrl("squashB", NONE, 2'd1);
    idle();
    checkCtrl("squashC", NONE, 2'd0);

    resetPulse("rstPerf");
    applyStimulus(5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("pLu", LU, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("pBr1", BR, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("pBr2", BR, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCtrl("brMs1", MS, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCtrl("brMs2", MS, 2'd1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCtrl("brMs3", MS, 2'd1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkCtrl("brReady", BR, 2'd1);
    idle();
    checkCtrl("brDone", NONE, 2'd0);
`ifdef STALL_PERF_EN
    checkOutput("cntLu", loadUseCnt, 32'd1);
    checkOutput("cntFlush", flushCnt, 32'd3);
    checkOutput("cntMs", memStallCnt, 32'd3);
`endif

    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkCtrl("tmoWait", MS, (i == 0) ? 2'd0 : 2'd1);
      checkOutput("tmoWait.memErr", {31'd0, memErr}, 32'd0);
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCtrl("halt", MS, 2'd2);
    checkOutput("halt.memErr", {31'd0, memErr}, 32'd1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkCtrl("haltHold", MS, 2'd2);
`ifdef STALL_PERF_EN
    checkOutput("cntMsHalt", memStallCnt, 32'd8);
`endif
    idle();
    checkCtrl("haltHold2", MS, 2'd2);
`ifdef STALL_PERF_EN
    checkOutput("cntFlushHalt", flushCnt, 32'd3);
`endif
    resetPulse("rstHalt");
    idle();
    checkCtrl("afterHalt", NONE, 2'd0);

    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCtrl("preRstWait", MS, 2'd1);
    resetPulse("rstWait");
    idle();
    checkCtrl("afterRstWait", NONE, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Hazard and stall scheduler for the 5-stage pipeline. It sequences the pipeline registers around the existing E-stage bypass network. It handles three cases:
- load-use hazards, which forwarding cannot cover;
- taken-branch redirects resolved in E;
- multi-cycle data-memory waits in M, with a timeout watchdog.

It drives the stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers and the PC enable.

Parameters:
REG_W, `REG_SIZE, register address width
TIMEOUT, 255, max consecutive MEM_WAIT cycles before HALT
TMO_W, 8, width of the wait counter; must satisfy TIMEOUT < 2**TMO_W
CNT_W, 32, perf counter width (STALL_PERF_EN only)

Ports:
clk  in  1  single clock; one clock domain, rising edge
reset  in  1  asynchronous, active-high
raddr1D  in  REG_W  D-stage source register 1
raddr2D  in  REG_W  D-stage source register 2
writeRegE  in  REG_W  E-stage destination register
memToRegE  in  1  E-stage instruction is a load
branchTakenE  in  1  redirect resolved in E
dmemReqM  in  1  M-stage memory access active
dmemReadyM  in  1  data memory completes this cycle
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
stallM  out  1  hold E/M register
flushD  out  1  clear F/D register (bubble)
flushE  out  1  clear D/E register (bubble)
flushW  out  1  clear M/W register (bubble)
memErr  out  1  sticky timeout flag
state  out  2  current FSM state (debug)

Behaviour:
- One clock; reset is asynchronous and active-high.
- While reset is high: state=RUN, wait counter=0, memErr=0, all stall/flush outputs=0.
- FSM states: RUN=0, MEM_WAIT=1, HALT=2 (3 unused; it decodes as HALT).
- memStall = dmemReqM & ~dmemReadyM.
- loadUse = memToRegE & (writeRegE != 0) & ((raddr1D == writeRegE) | (raddr2D == writeRegE)).
- Stall/flush outputs are combinational from state and inputs, with zero-cycle latency. Priority is HALT > memStall > branchTakenE > loadUse.
  - HALT: stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0. Held until reset.
  - memStall (RUN or MEM_WAIT): stallF/D/E/M=1, flushW=1, flushD=flushE=0. A pending branch or load-use waits until the stall releases.
  - branchTakenE, no memStall: flushD=1, flushE=1, no stalls. Exactly 2 bubbles.
  - loadUse, no memStall, no branch: stallF=1, stallD=1, flushE=1. Exactly 1 bubble; the hazard clears next cycle because the load has moved to M.
  - A load-use and a taken branch cannot coexist in E; if both assert, the branch wins.
- Transitions (wait counter = cnt):
  - RUN -> MEM_WAIT on memStall; cnt<=1.
  - MEM_WAIT -> RUN on dmemReadyM; cnt<=0. Stalls drop in the ready cycle itself.
  - MEM_WAIT stays while memStall and cnt<TIMEOUT; cnt<=cnt+1.
  - MEM_WAIT -> HALT when memStall and cnt==TIMEOUT; memErr<=1.
  - MEM_WAIT -> RUN if dmemReqM drops without ready (squashed access).
  - HALT is absorbing; only reset exits it.
- A ready arriving in the same cycle as the request causes no stall and no state change.
- Reset mid-MEM_WAIT returns to RUN immediately (asynchronous).

Optional Feature:
STALL_PERF_EN:
- When defined, adds three outputs of CNT_W bits: loadUseCnt (+1 per loadUse bubble cycle), memStallCnt (+1 per memStall cycle), flushCnt (+1 per branch flush).
- Counters are saturating, reset to 0, and count only effective events after priority resolution. HALT cycles are not counted.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: ctrl_state_t enum {RUN, MEM_WAIT, HALT}, PIPE_CTRL_TIMEOUT default constant, and the `REG_SIZE define reused from the existing defines.
- Sub-module load_use_check: combinational comparison of two D-stage sources against writeRegE, outputs loadUse. Instantiated once.

Test Plan:
- Load x5 in E (memToRegE=1, writeRegE=5), raddr1D=5 -> stallF=stallD=flushE=1 for 1 cycle, then 0.
- writeRegE=0 with memToRegE=1 and raddr2D=0 -> no stall, no flush.
- branchTakenE=1 for 1 cycle -> flushD=flushE=1 that cycle, no stalls.
- dmemReqM=1 with dmemReadyM low for 3 cycles then high -> stallF/D/E/M and flushW high for 3 cycles; state RUN->MEM_WAIT->RUN; stalls 0 in the ready cycle.
- TIMEOUT=4, dmemReadyM held low -> HALT after the 5th stall cycle, memErr=1, stalls stuck at 1. Reset pulse -> RUN, memErr=0.
- Branch during memStall -> flushD/flushE=0 until ready; in the ready cycle flushD=flushE=1. With STALL_PERF_EN: memStallCnt and flushCnt match the cycles applied.
